// File: rtl/frame_bist_pkg.sv
// rtl/frame_bist_pkg.sv - shared types, polynomials and LFSR step for the frame BIST.
package frame_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_INIT = 32'hFFFFFFFF;

    // Galois form: shift right, fold the polynomial in when the bit shifted out was set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/frame_bist_misr.sv
// rtl/frame_bist_misr.sv - 32-bit MISR compressing a PIXEL_W-wide stream, with load and enable.
module frame_bist_misr
    import frame_bist_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [PIXEL_W-1:0] data_i,
    output logic [31:0]        sig_o,
    output logic [31:0]        sig_next_o
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;
    logic [31:0] data_ext;

    always_comb begin
        data_ext                = '0;
        data_ext[PIXEL_W-1:0]   = data_i;
        sig_d                   = sig_q;
        if (load_i) begin
            sig_d = MISR_INIT;
        end else if (en_i) begin
            sig_d = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0)) ^ data_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/frame_bist.sv
// rtl/frame_bist.sv - LFSR frame generator, MISR capture and sync/timeout checker for streaming filters.
// Optional FRAME_BIST_ERR_INJECT_EN adds err_inject, flipping bit 0 of the next driven pixel.
module frame_bist
    import frame_bist_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int PIXEL_W      = 8,
    parameter int NUM_FRAMES   = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               reset,
`ifdef FRAME_BIST_ERR_INJECT_EN
    input  logic               err_inject,
`endif
    input  logic               start,
    input  logic [31:0]        seed,
    input  logic [31:0]        golden_sig,
    output logic               io_frame_sync_in,
    output logic [PIXEL_W-1:0] io_data_in,
    input  logic               io_frame_sync_out,
    input  logic [PIXEL_W-1:0] io_data_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic               sync_err,
    output logic [31:0]        signature
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int TOTAL      = NUM_FRAMES * IMAGE_SIZE;
    localparam int IN_W       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int OUT_W      = $clog2(TOTAL + 1);
    localparam int TMO_W      = $clog2(TIMEOUT + 1);

    bist_state_t        state_q;
    logic [31:0]        lfsr_q;
    logic [IN_W-1:0]    in_idx_q;
    logic [IN_W-1:0]    out_pix_q;
    logic [OUT_W-1:0]   out_idx_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               capturing_q;
    logic               io_frame_sync_in_q;
    logic [PIXEL_W-1:0] io_data_in_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               timeout_q;
    logic               sync_err_q;

    logic               start_accept;
    logic               cap_fire;
    logic               sync_viol;
    logic               last_pixel;
    logic [PIXEL_W-1:0] inj_mask;
    logic [31:0]        sig_now;
    logic [31:0]        sig_next;

    always_comb begin
        inj_mask = '0;
`ifdef FRAME_BIST_ERR_INJECT_EN
        inj_mask[0] = err_inject;
`endif
    end

    // Capture begins on the first output sync seen in FEED and then runs every cycle.
    assign start_accept = start && (state_q != FEED);
    assign cap_fire     = (state_q == FEED) && (capturing_q || io_frame_sync_out);
    assign sync_viol    = io_frame_sync_out != (out_pix_q == '0);
    assign last_pixel   = out_idx_q == OUT_W'(TOTAL - 1);

    frame_bist_misr #(
        .PIXEL_W (PIXEL_W)
    ) u_misr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start_accept),
        .en_i       (cap_fire),
        .data_i     (io_data_out),
        .sig_o      (sig_now),
        .sig_next_o (sig_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            lfsr_q             <= '0;
            in_idx_q           <= '0;
            out_pix_q          <= '0;
            out_idx_q          <= '0;
            tmo_cnt_q          <= '0;
            capturing_q        <= 1'b0;
            io_frame_sync_in_q <= 1'b0;
            io_data_in_q       <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            timeout_q          <= 1'b0;
            sync_err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    io_frame_sync_in_q <= 1'b0;
                    if (start) begin
                        state_q     <= FEED;
                        lfsr_q      <= (seed == 32'h0) ? 32'h1 : seed;
                        in_idx_q    <= '0;
                        out_pix_q   <= '0;
                        out_idx_q   <= '0;
                        tmo_cnt_q   <= '0;
                        capturing_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        sync_err_q  <= 1'b0;
                    end
                end
                FEED: begin
                    io_data_in_q       <= lfsr_q[PIXEL_W-1:0] ^ inj_mask;
                    io_frame_sync_in_q <= (in_idx_q == '0);
                    lfsr_q             <= lfsr_step(lfsr_q);
                    in_idx_q           <= (in_idx_q == IN_W'(IMAGE_SIZE - 1)) ? '0 : in_idx_q + IN_W'(1);
                    if (cap_fire) begin
                        capturing_q <= 1'b1;
                        out_idx_q   <= out_idx_q + OUT_W'(1);
                        out_pix_q   <= (out_pix_q == IN_W'(IMAGE_SIZE - 1)) ? '0 : out_pix_q + IN_W'(1);
                        if (sync_viol) begin
                            sync_err_q <= 1'b1;
                        end
                        if (last_pixel) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_next == golden_sig) && !(sync_err_q || sync_viol) && !timeout_q;
                        end
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_frame_sync_in = io_frame_sync_in_q;
    assign io_data_in       = io_data_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign timeout          = timeout_q;
    assign sync_err         = sync_err_q;
    assign signature        = sig_now;

endmodule

// File: tb/tb_frame_bist.sv
// tb/tb_frame_bist.sv - randomized self-checking bench for frame_bist around a pass-through filter.
module tb_frame_bist;

    localparam int IW    = 4;
    localparam int IH    = 4;
    localparam int PW    = 8;
    localparam int NF    = 2;
    localparam int TMO   = 64;
    localparam int D     = 3;
    localparam int NPIX  = IW * IH * NF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   seed;
    logic [31:0]   golden_sig;
    logic          err_inject = 1'b0;
    logic          io_frame_sync_in;
    logic [PW-1:0] io_data_in;
    logic          io_frame_sync_out;
    logic [PW-1:0] io_data_out;
    logic          busy, done, pass, timeout, sync_err;
    logic [31:0]   signature;

    int n_checks = 0;
    int n_errors = 0;

    // Filter stand-in: mode 0 clean delay line, 1 never syncs, 2 adds a sync at output index 5.
    int              mode  = 0;
    logic            tb_clr = 1'b0;
    logic [D-1:0]          sc_q = '0;
    logic [D-1:0][PW-1:0]  dc_q = '0;
    int              ocnt = -1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sc_q <= {sc_q[D-2:0], io_frame_sync_in};
        dc_q <= {dc_q[D-2:0], io_data_in};
        if (tb_clr) ocnt <= -1;
        else if (ocnt >= 0) ocnt <= ocnt + 1;
        else if (io_frame_sync_out) ocnt <= 1;
    end

    assign io_frame_sync_out = (mode == 1) ? 1'b0 : (sc_q[D-1] | (mode == 2 && ocnt == 5));
    assign io_data_out       = dc_q[D-1];

    frame_bist #(
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .PIXEL_W      (PW),
        .NUM_FRAMES   (NF),
        .TIMEOUT      (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef FRAME_BIST_ERR_INJECT_EN
        .err_inject        (err_inject),
`endif
        .start             (start),
        .seed              (seed),
        .golden_sig        (golden_sig),
        .io_frame_sync_in  (io_frame_sync_in),
        .io_data_in        (io_data_in),
        .io_frame_sync_out (io_frame_sync_out),
        .io_data_out       (io_data_out),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timeout           (timeout),
        .sync_err          (sync_err),
        .signature         (signature)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: pixel k of the pass-through output is the k-th LFSR state's low byte.
    function automatic logic [31:0] model_sig(input logic [31:0] s, input int flip_idx);
        logic [31:0] l;
        logic [31:0] sig;
        logic [31:0] px;
        l   = (s == 0) ? 32'd1 : s;
        sig = 32'hFFFF_FFFF;
        for (int k = 0; k < NPIX; k++) begin
            px = l % 256;
            if (k == flip_idx) px = px ^ 32'd1;
            sig = (sig * 2) ^ ((sig >= 32'h8000_0000) ? 32'h04C1_1DB7 : 32'h0) ^ px;
            l = (l / 2) ^ ((l % 2 == 1) ? 32'h8020_0003 : 32'h0);
        end
        return sig;
    endfunction

    // Runs one BIST pass; edges counts clock edges after the start edge until done.
    task automatic run(input logic [31:0] s, input logic [31:0] g, input int m,
                       input int poke_at, input int inj_at, output int edges);
        mode       = m;
        seed       = s;
        golden_sig = g;
        @(negedge clk);
        start  = 1'b1;
        tb_clr = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tb_clr = 1'b0;
        check("busy_after_start", busy, 1);
        edges = 0;
        while (!done && edges < 300) begin
            start      = (edges == poke_at);
            err_inject = (edges == inj_at);
            if (edges == poke_at) seed = $urandom;
            @(negedge clk);
            edges++;
        end
        start      = 1'b0;
        err_inject = 1'b0;
        if (!done) check("done_never_rose", 0, 1);
        check("busy_at_done", busy, 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int          e;
        logic [31:0] s;
        logic [31:0] m;
        logic        want;

        reset      = 1'b1;
        start      = 1'b1;
        seed       = 32'h1;
        golden_sig = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("rst_sync_in", io_frame_sync_in, 0);
        end
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_signature", signature, 0);
        check("rst_data_in", io_data_in, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);

        m = model_sig(32'h1, -1);
        run(32'h1, m, 0, -1, -1, e);
        check("clean_done_edge", e, 36);
        check("clean_pass", pass, 1);
        check("clean_sync_err", sync_err, 0);
        check("clean_timeout", timeout, 0);
        check("clean_sig", signature, m);

        run(32'h1, m ^ 32'h1, 0, -1, -1, e);
        check("badgold_pass", pass, 0);
        check("badgold_timeout", timeout, 0);
        check("badgold_sync_err", sync_err, 0);
        check("badgold_sig", signature, m);

        for (int i = 0; i < 5; i++) begin
            s    = (i == 0) ? 32'h0 : $urandom;
            m    = model_sig(s, -1);
            want = $urandom_range(0, 1);
            run(s, want ? m : m ^ (32'h1 << $urandom_range(0, 31)), 0, (i == 1) ? 10 : -1, -1, e);
            check("rand_done_edge", e, 36);
            check("rand_pass", pass, want);
            check("rand_sig", signature, m);
        end

        run(32'h1234_5678, 32'hFFFF_FFFF, 1, -1, -1, e);
        check("tmo_done_edge", e, 64);
        check("tmo_timeout", timeout, 1);
        check("tmo_pass", pass, 0);
        check("tmo_sig", signature, 32'hFFFF_FFFF);

        s = $urandom;
        m = model_sig(s, -1);
        run(s, m, 2, -1, -1, e);
        check("xsync_done_edge", e, 36);
        check("xsync_sync_err", sync_err, 1);
        check("xsync_pass", pass, 0);
        check("xsync_timeout", timeout, 0);
        check("xsync_sig", signature, m);

        mode = 0;
        seed = s;
        golden_sig = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sig", signature, 0);
        repeat (6) @(negedge clk);
        run(s, m, 0, -1, -1, e);
        check("rerun_done_edge", e, 36);
        check("rerun_pass", pass, 1);
        check("rerun_sig", signature, m);

`ifdef FRAME_BIST_ERR_INJECT_EN
        s = $urandom;
        m = model_sig(s, -1);
        run(s, m, 0, -1, 10, e);
        check("inj_pass", pass, 0);
        check("inj_sig", signature, model_sig(s, 10));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
